ip_codma_mc: RTL and testbench

Multi-channel successor of the single-channel CODMA top. Holds NUM_CH independent copy channels, each started by its own task pointer, and time-shares one word-wide bus master among them with round-robin, burst-granular arbitration. Each channel fetches a 3-word descriptor, copies the payload in bursts of at most BURST_MAX words through one shared staging buffer, writes a status word, and raises its own interrupt.

---
 rtl/ip_codma_mc.sv | 244 ++++++++++++++++++++++++
 tb/tb_ip_codma_mc.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ip_codma_mc.sv
// rtl/ip_codma_mc.sv - multi-channel descriptor copy DMA sharing one burst bus master
// Round-robin arbitration at burst granularity; one staging buffer serves every channel.
module ip_codma_mc #(
  parameter int NUM_CH    = 2,
  parameter int BURST_MAX = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [NUM_CH-1:0]    start_i,
  input  logic [NUM_CH-1:0]    stop_i,
  input  logic [NUM_CH*32-1:0] task_pointer_i,
  input  logic [NUM_CH*32-1:0] status_pointer_i,
  output logic [NUM_CH-1:0]    busy_o,
  output logic [NUM_CH-1:0]    irq_o,
  output logic                 bus_req_o,
  output logic                 bus_we_o,
  output logic [31:0]          bus_addr_o,
  output logic [4:0]           bus_len_o,
  input  logic                 bus_gnt_i,
  input  logic [31:0]          bus_rdata_i,
  input  logic                 bus_rvalid_i,
  output logic [31:0]          bus_wdata_o,
  input  logic                 bus_wready_i
);

  localparam int              CW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int              BW       = $clog2(BURST_MAX);
  localparam logic [4:0]      BMAX_LEN = 5'(BURST_MAX);
  localparam logic [29:0]     BMAX_REM = 30'(BURST_MAX);
  localparam logic [CW:0]     NCH_W    = (CW+1)'(NUM_CH);
  localparam logic [CW-1:0]   LAST_CH  = CW'(NUM_CH - 1);

  typedef enum logic [2:0] {S_IDLE, S_DESC, S_READ, S_WRITE, S_STATUS} state_t;

  state_t state_q, state_d;

  logic [31:0]       task_ptr_q [NUM_CH];
  logic [31:0]       stat_ptr_q [NUM_CH];
  logic [31:0]       src_q      [NUM_CH];
  logic [31:0]       dst_q      [NUM_CH];
  logic [29:0]       rem_q      [NUM_CH];
  logic [NUM_CH-1:0] loaded_q;
  logic [NUM_CH-1:0] stop_q;
  logic [NUM_CH-1:0] busy_q;
  logic [NUM_CH-1:0] irq_q;
  logic [31:0]       buf_q      [BURST_MAX];
  logic [CW-1:0]     cur_q;
  logic [CW-1:0]     rr_q;
  logic [4:0]        beat_q;
  logic [4:0]        n_q;

  logic          found;
  logic [CW-1:0] pick;
  logic [CW:0]   arb_sum;
  logic [CW-1:0] arb_idx;
  logic [4:0]    pick_n;
  logic          pick_copy;
  logic          data_phase;
  logic          rd_beat;
  logic          wr_beat;
  logic          last_beat;
  logic [4:0]    beat_nxt;
  logic [31:0]   status_word;

  assign busy_o = busy_q;
  assign irq_o  = irq_q;

  // First busy channel at or after rr_q, wrapping modulo NUM_CH.
  always_comb begin
    found   = 1'b0;
    pick    = '0;
    arb_sum = '0;
    arb_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      arb_sum = {1'b0, rr_q} + (CW+1)'(i);
      if (arb_sum >= NCH_W) arb_sum = arb_sum - NCH_W;
      arb_idx = arb_sum[CW-1:0];
      if (!found && busy_q[arb_idx]) begin
        found = 1'b1;
        pick  = arb_idx;
      end
    end
  end

  always_comb begin
    pick_n      = (rem_q[pick] >= BMAX_REM) ? BMAX_LEN : rem_q[pick][4:0];
    pick_copy   = loaded_q[pick] && (rem_q[pick] != 30'd0) && !stop_q[pick];
    data_phase  = !bus_req_o;
    rd_beat     = data_phase && bus_rvalid_i;
    wr_beat     = data_phase && bus_wready_i;
    last_beat   = (beat_q == n_q - 5'd1);
    beat_nxt    = beat_q + 5'd1;
    status_word = (rem_q[cur_q] == 30'd0) ? 32'h1 : {rem_q[cur_q], 2'b10};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          if (!loaded_q[pick]) state_d = S_DESC;
          else if (pick_copy)  state_d = S_READ;
          else                 state_d = S_STATUS;
        end
      end
      S_DESC:   if (rd_beat && last_beat) state_d = S_IDLE;
      S_READ:   if (rd_beat && last_beat) state_d = S_WRITE;
      S_WRITE:  if (wr_beat && last_beat) state_d = S_IDLE;
      S_STATUS: if (wr_beat)              state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      rr_q        <= '0;
      beat_q      <= '0;
      n_q         <= '0;
      loaded_q    <= '0;
      stop_q      <= '0;
      busy_q      <= '0;
      irq_q       <= '0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_len_o   <= '0;
      bus_wdata_o <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        task_ptr_q[c] <= '0;
        stat_ptr_q[c] <= '0;
        src_q[c]      <= '0;
        dst_q[c]      <= '0;
        rem_q[c]      <= '0;
      end
      for (int k = 0; k < BURST_MAX; k++) buf_q[k] <= '0;
    end else begin
      state_q <= state_d;
      irq_q   <= '0;

      // A start on an idle channel wins over a same-cycle stop.
      for (int c = 0; c < NUM_CH; c++) begin
        if (start_i[c] && !busy_q[c]) begin
          busy_q[c]     <= 1'b1;
          loaded_q[c]   <= 1'b0;
          stop_q[c]     <= 1'b0;
          rem_q[c]      <= '0;
          task_ptr_q[c] <= task_pointer_i[32*c +: 32];
          stat_ptr_q[c] <= status_pointer_i[32*c +: 32];
        end else if (stop_i[c] && busy_q[c] && !start_i[c]) begin
          stop_q[c] <= 1'b1;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (found) begin
            cur_q     <= pick;
            rr_q      <= (pick == LAST_CH) ? '0 : pick + 1'b1;
            beat_q    <= '0;
            bus_req_o <= 1'b1;
            if (!loaded_q[pick]) begin
              bus_we_o   <= 1'b0;
              bus_addr_o <= task_ptr_q[pick];
              bus_len_o  <= 5'd3;
              n_q        <= 5'd3;
            end else if (pick_copy) begin
              bus_we_o   <= 1'b0;
              bus_addr_o <= src_q[pick];
              bus_len_o  <= pick_n;
              n_q        <= pick_n;
            end else begin
              bus_we_o   <= 1'b1;
              bus_addr_o <= stat_ptr_q[pick];
              bus_len_o  <= 5'd1;
              n_q        <= 5'd1;
            end
          end
        end
        S_DESC: begin
          if (bus_req_o) begin
            if (bus_gnt_i) bus_req_o <= 1'b0;
          end else if (bus_rvalid_i) begin
            beat_q <= beat_nxt;
            case (beat_q[1:0])
              2'd0:    src_q[cur_q] <= bus_rdata_i;
              2'd1:    dst_q[cur_q] <= bus_rdata_i;
              default: begin
                rem_q[cur_q]    <= bus_rdata_i[31:2];
                loaded_q[cur_q] <= 1'b1;
              end
            endcase
          end
        end
        S_READ: begin
          if (bus_req_o) begin
            if (bus_gnt_i) bus_req_o <= 1'b0;
          end else if (bus_rvalid_i) begin
            buf_q[beat_q[BW-1:0]] <= bus_rdata_i;
            beat_q                <= beat_nxt;
            if (last_beat) begin
              beat_q     <= '0;
              bus_req_o  <= 1'b1;
              bus_we_o   <= 1'b1;
              bus_addr_o <= dst_q[cur_q];
            end
          end
        end
        S_WRITE: begin
          if (bus_req_o) begin
            if (bus_gnt_i) begin
              bus_req_o   <= 1'b0;
              bus_wdata_o <= buf_q[0];
            end
          end else if (bus_wready_i) begin
            beat_q <= beat_nxt;
            if (last_beat) begin
              src_q[cur_q] <= src_q[cur_q] + {25'd0, n_q, 2'b00};
              dst_q[cur_q] <= dst_q[cur_q] + {25'd0, n_q, 2'b00};
              rem_q[cur_q] <= rem_q[cur_q] - {25'd0, n_q};
            end else begin
              bus_wdata_o <= buf_q[beat_nxt[BW-1:0]];
            end
          end
        end
        S_STATUS: begin
          if (bus_req_o) begin
            if (bus_gnt_i) begin
              bus_req_o   <= 1'b0;
              bus_wdata_o <= status_word;
            end
          end else if (bus_wready_i) begin
            busy_q[cur_q]   <= 1'b0;
            irq_q[cur_q]    <= 1'b1;
            loaded_q[cur_q] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ip_codma_mc.sv
// tb/tb_ip_codma_mc.sv - directed and randomized checks of ip_codma_mc against a burst-level model
module tb_ip_codma_mc;

  localparam int NUM_CH    = 2;
  localparam int BURST_MAX = 8;

  logic                 clk;
  logic                 reset_i;
  logic [NUM_CH-1:0]    start_i;
  logic [NUM_CH-1:0]    stop_i;
  logic [NUM_CH*32-1:0] task_pointer_i;
  logic [NUM_CH*32-1:0] status_pointer_i;
  logic [NUM_CH-1:0]    busy_o;
  logic [NUM_CH-1:0]    irq_o;
  logic                 bus_req_o;
  logic                 bus_we_o;
  logic [31:0]          bus_addr_o;
  logic [4:0]           bus_len_o;
  logic                 bus_gnt_i;
  logic [31:0]          bus_rdata_i;
  logic                 bus_rvalid_i;
  logic [31:0]          bus_wdata_o;
  logic                 bus_wready_i;

  ip_codma_mc #(.NUM_CH(NUM_CH), .BURST_MAX(BURST_MAX)) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .start_i         (start_i),
    .stop_i          (stop_i),
    .task_pointer_i  (task_pointer_i),
    .status_pointer_i(status_pointer_i),
    .busy_o          (busy_o),
    .irq_o           (irq_o),
    .bus_req_o       (bus_req_o),
    .bus_we_o        (bus_we_o),
    .bus_addr_o      (bus_addr_o),
    .bus_len_o       (bus_len_o),
    .bus_gnt_i       (bus_gnt_i),
    .bus_rdata_i     (bus_rdata_i),
    .bus_rvalid_i    (bus_rvalid_i),
    .bus_wdata_o     (bus_wdata_o),
    .bus_wready_i    (bus_wready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [4:0]  len;
  } burst_t;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [4096];
  burst_t got_q [$];
  burst_t exp_q [$];
  int gnt_delay = 0;
  int gap_max   = 0;
  int stab_err  = 0;
  int rst_epoch = 0;
  int multi_irq_err = 0;
  int irq_busy_err  = 0;
  int irq_cnt  [NUM_CH] = '{default: 0};
  int irq_base [NUM_CH];

  logic [31:0] m_tp [NUM_CH], m_sp [NUM_CH], m_src [NUM_CH], m_dst [NUM_CH];
  logic [31:0] exp_status [NUM_CH];
  int m_words [NUM_CH], m_stop_after [NUM_CH], m_copied [NUM_CH];
  bit m_act [NUM_CH];
  int m_rr = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a[13:2]);
  endfunction

  function automatic burst_t mk(input logic we, input logic [31:0] a, input int n);
    return {we, a, 5'(n)};
  endfunction

  always @(posedge clk) if (reset_i) rst_epoch <= rst_epoch + 1;

  always @(negedge clk) begin
    if ($countones(irq_o) > 1) multi_irq_err <= multi_irq_err + 1;
    for (int c = 0; c < NUM_CH; c++)
      if (irq_o[c]) begin
        irq_cnt[c] <= irq_cnt[c] + 1;
        if (busy_o[c]) irq_busy_err <= irq_busy_err + 1;
      end
  end

  // Bus slave: grant after gnt_delay cycles, then len beats with random gaps, backed by mem.
  task automatic serve();
    logic we; logic [31:0] addr; logic [4:0] len; int ep;
    we = bus_we_o; addr = bus_addr_o; len = bus_len_o; ep = rst_epoch;
    repeat (gnt_delay) begin
      @(negedge clk);
      if (rst_epoch != ep) return;
      if ({bus_req_o, bus_we_o, bus_addr_o, bus_len_o} !== {1'b1, we, addr, len}) stab_err++;
    end
    bus_gnt_i = 1'b1;
    got_q.push_back(mk(we, addr, int'(len)));
    @(negedge clk);
    bus_gnt_i = 1'b0;
    if (rst_epoch != ep) return;
    if (bus_req_o !== 1'b0) stab_err++;
    for (int k = 0; k < int'(len); k++) begin
      int g;
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (g) @(negedge clk);
      if (rst_epoch != ep) return;
      if (!we) begin
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = mem[widx(addr + 32'(4 * k))];
      end else begin
        bus_wready_i = 1'b1;
        mem[widx(addr + 32'(4 * k))] = bus_wdata_o;
      end
      @(negedge clk);
      bus_rvalid_i = 1'b0;
      bus_wready_i = 1'b0;
    end
  endtask

  initial begin : slave
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_wready_i = 1'b0; bus_rdata_i = '0;
    @(negedge clk);
    forever begin
      bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_wready_i = 1'b0;
      if (bus_req_o === 1'b1 && reset_i === 1'b0) serve();
      else @(negedge clk);
    end
  end

  task automatic begin_test();
    got_q.delete();
    for (int c = 0; c < NUM_CH; c++) begin
      m_act[c] = 1'b0;
      irq_base[c] = irq_cnt[c];
    end
  endtask

  task automatic setup_task(input int c, input int len_bytes, input int stop_after);
    m_tp[c]  = 32'h100 + 32'(c * 16);
    m_sp[c]  = 32'h200 + 32'(c * 4);
    m_src[c] = 32'h1000 + 32'(c * 32'h800);
    m_dst[c] = 32'h2000 + 32'(c * 32'h800);
    m_words[c] = len_bytes >> 2;
    m_stop_after[c] = stop_after;
    m_act[c] = 1'b1;
    mem[widx(m_tp[c])]     = m_src[c];
    mem[widx(m_tp[c]) + 1] = m_dst[c];
    mem[widx(m_tp[c]) + 2] = 32'(len_bytes) | 32'($urandom_range(3, 0));
    mem[widx(m_sp[c])]     = 32'hFFFF_FFFF;
    for (int w = 0; w < 64; w++) begin
      mem[widx(m_src[c]) + w] = $urandom;
      mem[widx(m_dst[c]) + w] = 32'hDEAD_0000 | 32'(w);
    end
  endtask

  // Burst-by-burst schedule: each arbitration slot serves the next active channel after the last one.
  task automatic build_expected();
    int phase [NUM_CH]; int rem [NUM_CH]; int nb [NUM_CH];
    logic [31:0] s [NUM_CH]; logic [31:0] d [NUM_CH];
    int c, n;
    exp_q.delete();
    for (int i = 0; i < NUM_CH; i++) begin
      phase[i] = m_act[i] ? 0 : 2; rem[i] = m_words[i]; nb[i] = 0;
      s[i] = m_src[i]; d[i] = m_dst[i]; m_copied[i] = 0;
    end
    forever begin
      c = -1;
      for (int i = 0; i < NUM_CH; i++)
        if (c < 0 && phase[(m_rr + i) % NUM_CH] != 2) c = (m_rr + i) % NUM_CH;
      if (c < 0) break;
      if (phase[c] == 0) begin
        exp_q.push_back(mk(1'b0, m_tp[c], 3));
        phase[c] = 1;
      end else if (rem[c] > 0 && nb[c] != m_stop_after[c]) begin
        n = (rem[c] < BURST_MAX) ? rem[c] : BURST_MAX;
        exp_q.push_back(mk(1'b0, s[c], n));
        exp_q.push_back(mk(1'b1, d[c], n));
        s[c] = s[c] + 32'(4 * n); d[c] = d[c] + 32'(4 * n);
        rem[c] -= n; nb[c]++; m_copied[c] += n;
      end else begin
        exp_q.push_back(mk(1'b1, m_sp[c], 1));
        exp_status[c] = (rem[c] == 0) ? 32'h1 : (32'h2 | (32'(rem[c]) << 2));
        phase[c] = 2;
      end
      m_rr = (c + 1) % NUM_CH;
    end
  endtask

  task automatic start_ch(input logic [NUM_CH-1:0] mask, input logic [NUM_CH-1:0] stopm);
    @(negedge clk);
    for (int c = 0; c < NUM_CH; c++) begin
      task_pointer_i[32*c +: 32]   = m_tp[c];
      status_pointer_i[32*c +: 32] = m_sp[c];
    end
    start_i = mask; stop_i = stopm;
    @(negedge clk);
    start_i = '0; stop_i = '0;
    check("busy_rise", 64'(busy_o & mask), 64'(mask));
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    while (busy_o !== '0 && t < budget) begin @(negedge clk); t++; end
    check("done_in_time", 64'(t < budget), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_results();
    int mism, nmin;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!m_act[c]) continue;
      mism = 0;
      for (int w = 0; w < m_copied[c]; w++)
        if (mem[widx(m_dst[c]) + w] !== mem[widx(m_src[c]) + w]) mism++;
      check("dst_data", 64'(mism), 64'd0);
      check("dst_guard", 64'(mem[widx(m_dst[c]) + m_copied[c]]), 64'(32'hDEAD_0000 | 32'(m_copied[c])));
      check("status_word", 64'(mem[widx(m_sp[c])]), 64'(exp_status[c]));
      check("irq_pulses", 64'(irq_cnt[c] - irq_base[c]), 64'd1);
    end
    check("burst_count", 64'(got_q.size()), 64'(exp_q.size()));
    nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < nmin; i++) check("burst_fields", 64'(got_q[i]), 64'(exp_q[i]));
    check("req_stable", 64'(stab_err), 64'd0);
    check("irq_exclusive", 64'(multi_irq_err), 64'd0);
    check("irq_busy_fall", 64'(irq_busy_err), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  64'(busy_o), 64'd0);
    check({tag, "_irq"},   64'(irq_o), 64'd0);
    check({tag, "_req"},   64'(bus_req_o), 64'd0);
    check({tag, "_we"},    64'(bus_we_o), 64'd0);
    check({tag, "_addr"},  64'(bus_addr_o), 64'd0);
    check({tag, "_len"},   64'(bus_len_o), 64'd0);
    check({tag, "_wdata"}, 64'(bus_wdata_o), 64'd0);
  endtask

  initial begin : stim
    int t;
    reset_i = 1'b1; start_i = '0; stop_i = '0;
    task_pointer_i = '0; status_pointer_i = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_i = 1'b0;
    repeat (2) @(negedge clk);

    // 8-word copy, zero-wait bus
    begin_test(); setup_task(0, 32'h20, -1); build_expected();
    start_ch(2'b01, 2'b00); wait_done(2000); check_results();

    // 11 words: bursts of 8 then 3; a stop in the start cycle is ignored
    begin_test(); setup_task(0, 32'h2C, -1); build_expected();
    start_ch(2'b01, 2'b01); wait_done(2000); check_results();

    // zero-length task on channel 1: descriptor then status only
    begin_test(); setup_task(1, 0, -1); build_expected();
    start_ch(2'b10, 2'b00); wait_done(2000); check_results();

    // two channels together; a start on busy channel 0 is ignored
    begin_test(); setup_task(0, 32'h40, -1); setup_task(1, 32'h40, -1); build_expected();
    start_ch(2'b11, 2'b00);
    repeat (20) @(negedge clk);
    task_pointer_i[31:0] = 32'h300; start_i = 2'b01;
    @(negedge clk);
    start_i = '0; task_pointer_i[31:0] = m_tp[0];
    wait_done(3000); check_results();

    // stop during the first read of a 24-word task
    begin_test(); setup_task(0, 32'h60, 1); build_expected();
    start_ch(2'b01, 2'b00);
    t = 0;
    while (got_q.size() < 2 && t < 200) begin @(negedge clk); t++; end
    check("stop_window", 64'(t < 200), 64'd1);
    stop_i = 2'b01;
    @(negedge clk);
    stop_i = '0;
    wait_done(2000); check_results();
    check("stop_status_0x42", 64'(mem[widx(m_sp[0])]), 64'h42);

    // held-off grant and random beat gaps
    gnt_delay = 5; gap_max = 3;
    begin_test(); setup_task(1, 32'h2C, -1); build_expected();
    start_ch(2'b10, 2'b00); wait_done(4000); check_results();
    gnt_delay = 0; gap_max = 0;

    // reset in the middle of a write burst, then restart
    begin_test(); setup_task(0, 32'h40, -1);
    start_ch(2'b01, 2'b00);
    t = 0;
    while ((got_q.size() < 3 || !got_q[2].we) && t < 200) begin @(negedge clk); t++; end
    check("write_seen", 64'(t < 200), 64'd1);
    repeat (3) @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    check_reset_outputs("midreset");
    repeat (5) @(negedge clk);
    check("midreset_no_irq", 64'(irq_cnt[0] - irq_base[0]), 64'd0);
    m_rr = 0;
    begin_test(); setup_task(0, 32'h40, -1); build_expected();
    start_ch(2'b01, 2'b00); wait_done(2000); check_results();

    // randomized lengths and bus timing on both channels
    for (int r = 0; r < 3; r++) begin
      gnt_delay = int'($urandom_range(2, 0)); gap_max = 2;
      begin_test();
      for (int c = 0; c < NUM_CH; c++) setup_task(c, int'($urandom_range(40, 0)) * 4, -1);
      build_expected();
      start_ch(2'b11, 2'b00); wait_done(6000); check_results();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
